// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: launches an external expansion engine, buffers the
// expanded words and serves 128-bit round keys to two round-robin requesters.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS  = 14,
  parameter int EXP_TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key_in,
  output logic         key_ready,
  output logic         key_err,
  output logic         kexp_start,
  output logic [255:0] kexp_key,
  input  logic         kexp_word_valid,
  input  logic [31:0]  kexp_word,
  input  logic         kexp_done,
  input  logic         req0,
  input  logic         req1,
  input  logic [3:0]   rnd0,
  input  logic [3:0]   rnd1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [127:0] rk_out,
  output logic         rk_bad,
  output logic [2:0]   dbg_state
);
  localparam int            WORDS    = 4 * (NUM_ROUNDS + 1);
  localparam int            TW       = $clog2(EXP_TIMEOUT + 1);
  localparam logic [6:0]    WORDS_C  = 7'(WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(EXP_TIMEOUT - 1);
  localparam logic [3:0]    MAX_RND  = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COLLECT = 3'd2,
    READY   = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   kexp_key_q, kexp_key_d;
  logic [6:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           word_we;
  logic           kexp_start_q, key_ready_q, key_err_q;
  logic           gnt0_q, gnt1_q, rk_bad_q;
  logic [127:0]   rk_out_q, rk_d;
  logic           last1_q, last1_d;
  logic           arb_en, pick0, pick1, sel_bad;
  logic [3:0]     sel_rnd;
  logic [5:0]     base;
  logic [31:0]    kbuf_q [WORDS];

  // Engine handshake: kexp_word_valid is a strobe with no back-pressure; every
  // valid cycle in COLLECT delivers exactly one word, w[0] first.
  always_comb begin
    state_d    = state_q;
    kexp_key_d = kexp_key_q;
    wcnt_d     = wcnt_q;
    timer_d    = timer_q;
    word_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          state_d    = START;
          kexp_key_d = key_in;
        end
      end
      START: begin
        wcnt_d  = '0;
        timer_d = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        timer_d = timer_q + TW'(1);
        if (kexp_word_valid && (wcnt_q < WORDS_C)) begin
          word_we = 1'b1;
          wcnt_d  = wcnt_q + 7'd1;
        end
        // A word arriving with done is already in wcnt_d when done is judged.
        if (kexp_word_valid && (wcnt_q == WORDS_C)) state_d = ERROR;
        else if (kexp_done)                          state_d = (wcnt_d == WORDS_C) ? READY : ERROR;
        else if (timer_q == TMO_LAST)                state_d = ERROR;
      end
      READY, ERROR: begin
        if (key_load) begin
          state_d    = START;
          kexp_key_d = key_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last1_q set means requester 1 won most recently, so requester 0 wins a tie.
  always_comb begin
    arb_en  = (state_q == READY) && !key_load;
    pick0   = arb_en && req0 && (!req1 || last1_q);
    pick1   = arb_en && req1 && !pick0;
    sel_rnd = pick1 ? rnd1 : rnd0;
    sel_bad = sel_rnd > MAX_RND;
    base    = {sel_rnd, 2'b00};
    last1_d = pick1 ? 1'b1 : (pick0 ? 1'b0 : last1_q);
    rk_d    = rk_out_q;
    if (pick0 || pick1) begin
      rk_d = sel_bad ? '0 : {kbuf_q[base], kbuf_q[base + 6'd1],
                             kbuf_q[base + 6'd2], kbuf_q[base + 6'd3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      kexp_key_q   <= '0;
      wcnt_q       <= '0;
      timer_q      <= '0;
      kexp_start_q <= 1'b0;
      key_ready_q  <= 1'b0;
      key_err_q    <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rk_bad_q     <= 1'b0;
      rk_out_q     <= '0;
      last1_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      kexp_key_q   <= kexp_key_d;
      wcnt_q       <= wcnt_d;
      timer_q      <= timer_d;
      kexp_start_q <= (state_q == START);
      key_ready_q  <= (state_d == READY);
      key_err_q    <= (state_d == ERROR);
      gnt0_q       <= pick0;
      gnt1_q       <= pick1;
      rk_bad_q     <= (pick0 || pick1) && sel_bad;
      rk_out_q     <= rk_d;
      last1_q      <= last1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) kbuf_q[wcnt_q[5:0]] <= kexp_word;
  end

  assign key_ready  = key_ready_q;
  assign key_err    = key_err_q;
  assign kexp_start = kexp_start_q;
  assign kexp_key   = kexp_key_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rk_out     = rk_out_q;
  assign rk_bad     = rk_bad_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: an AES-256 expansion engine model feeds the block and
// a round-key / arbitration reference model predicts every grant.
module tb_aes_key_sched_ctrl;
  localparam int         NR      = 14;
  localparam int         WORDS   = 4 * (NR + 1);
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [255:0] key_in;
  logic         key_ready, key_err, kexp_start;
  logic [255:0] kexp_key;
  logic         kexp_word_valid;
  logic [31:0]  kexp_word;
  logic         kexp_done;
  logic         req0, req1;
  logic [3:0]   rnd0, rnd1;
  logic         gnt0, gnt1;
  logic [127:0] rk_out;
  logic         rk_bad;
  logic [2:0]   dbg_state;

  aes_key_sched_ctrl #(.NUM_ROUNDS(NR), .EXP_TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .key_ready(key_ready), .key_err(key_err), .kexp_start(kexp_start),
    .kexp_key(kexp_key), .kexp_word_valid(kexp_word_valid), .kexp_word(kexp_word),
    .kexp_done(kexp_done), .req0(req0), .req1(req1), .rnd0(rnd0), .rnd1(rnd1),
    .gnt0(gnt0), .gnt1(gnt1), .rk_out(rk_out), .rk_bad(rk_bad), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  int             n_total = 0;
  int             n_pass  = 0;
  logic [31:0]    w_model [WORDS];
  logic [127:0]   exp_q[$];
  logic [127:0]   last_rk_m;
  logic           last1_m;
  logic [0:255][7:0] sbox_v;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_v[x[31:24]], sbox_v[x[23:16]], sbox_v[x[15:8]], sbox_v[x[7:0]]};
  endfunction

  // FIPS-197 AES-256 key expansion (Nk = 8).
  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w_model[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < WORDS; i++) begin
      t = w_model[i-1];
      if (i % 8 == 0)      t = sub_word({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = sub_word(t);
      w_model[i] = w_model[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input logic [3:0] r);
    if (r > NR) return '0;
    return {w_model[4*r], w_model[4*r+1], w_model[4*r+2], w_model[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks (all start and end on a falling edge) ----------------
  task automatic check_reset_state(input string tag);
    check({tag, "_kexp_start"}, kexp_start, 0);
    check({tag, "_key_ready"},  key_ready, 0);
    check({tag, "_key_err"},    key_err, 0);
    check({tag, "_gnt0"},       gnt0, 0);
    check({tag, "_gnt1"},       gnt1, 0);
    check({tag, "_rk_bad"},     rk_bad, 0);
    check({tag, "_rk_out"},     rk_out, 0);
    check({tag, "_kexp_key"},   kexp_key, 0);
    check({tag, "_state"},      dbg_state, ST_IDLE);
  endtask

  task automatic load_key(input logic [255:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    check("load_ready_low", key_ready, 0);
    check("load_err_low", key_err, 0);
  endtask

  task automatic wait_start(input logic [255:0] k);
    int n = 0;
    while (kexp_start !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", kexp_start, 1);
    check("kexp_key", kexp_key, k);
  endtask

  task automatic stream(input int nw, input bit done_last, input bit poke);
    int extra = 0;
    for (int i = 0; i < nw; i++) begin
      kexp_word_valid = 1'b1;
      kexp_word       = (i < WORDS) ? w_model[i] : $urandom;
      kexp_done       = done_last && (i == nw - 1);
      key_load        = poke && (i == 5);
      if (poke && i == 5) key_in = rand256();
      @(negedge clk);
      if (kexp_start === 1'b1) extra++;
    end
    kexp_word_valid = 1'b0;
    kexp_done       = 1'b0;
    key_load        = 1'b0;
    check("start_one_cycle", extra, 0);
  endtask

  task automatic ready_cycle(input logic q0, input logic q1, input logic [3:0] r0, input logic [3:0] r1);
    logic g0, g1;
    logic [3:0] r;
    req0 = q0; req1 = q1; rnd0 = r0; rnd1 = r1;
    // Tie goes to whichever requester did not win last time.
    if (q0 && q1) begin
      g0 = last1_m;
      g1 = !last1_m;
    end else begin
      g0 = q0;
      g1 = q1;
    end
    if (g0 || g1) last1_m = g1;
    r = g1 ? r1 : r0;
    if (g0 || g1) exp_q.push_back(model_rk(r));
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("gnt_one_hot", gnt0 & gnt1, 0);
    check("rk_bad", rk_bad, (g0 || g1) && (r > NR));
    if (g0 || g1) last_rk_m = exp_q.pop_front();
    check("rk_out", rk_out, last_rk_m);
  endtask

  // ---------------- directed / randomized sequence ----------------
  initial begin
    logic [255:0] k0, k1, kf;
    int cyc;
    int n_st;
    sbox_v = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
              128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
              128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
              128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
              128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
              128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
              128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
              128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    rst = 1'b1; key_load = 1'b0; key_in = '0;
    kexp_word_valid = 1'b0; kexp_word = '0; kexp_done = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rnd0 = '0; rnd1 = '0;
    last_rk_m = '0; last1_m = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Known-answer key and normal expansion, done arriving with the last word.
    k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    expand(k0);
    load_key(k0);
    wait_start(k0);
    stream(WORDS, 1, 0);
    check("ready_after_done", key_ready, 1);
    check("no_err_after_done", key_err, 0);

    ready_cycle(1, 0, 4'd0, 4'd0);
    check("rk_round0_kat", rk_out, 128'h000102030405060708090a0b0c0d0e0f);
    ready_cycle(0, 0, 4'd0, 4'd0);
    ready_cycle(1, 0, 4'd14, 4'd0);
    check("rk_round14_kat", rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    ready_cycle(0, 1, 4'd0, 4'd15);
    check("bad_gnt1", gnt1, 1);
    check("bad_flag", rk_bad, 1);
    check("bad_rk_zero", rk_out, 0);

    // Both held for four cycles: strict alternation starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      ready_cycle(1, 1, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
      check("alt_gnt0", gnt0, (i % 2) == 0);
    end

    for (int i = 0; i < 40; i++)
      ready_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Reload in READY with a simultaneous request: no grant, restart follows.
    k1 = rand256();
    expand(k1);
    req0 = 1'b1; rnd0 = 4'd0; key_in = k1; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0; req0 = 1'b0;
    check("reload_no_gnt0", gnt0, 0);
    check("reload_no_gnt1", gnt1, 0);
    check("reload_ready_low", key_ready, 0);
    check("reload_start_later", kexp_start, 0);
    @(negedge clk);
    check("reload_start", kexp_start, 1);
    check("reload_key", kexp_key, k1);
    stream(WORDS, 1, 1);
    check("reload_ready", key_ready, 1);
    check("collect_load_ignored", kexp_key, k1);
    check("rk_hold_across_reload", rk_out, last_rk_m);
    for (int i = 0; i < 12; i++)
      ready_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Fault: done after only 59 words.
    kf = rand256(); expand(kf);
    load_key(kf);
    wait_start(kf);
    stream(WORDS - 1, 0, 0);
    kexp_done = 1'b1;
    @(negedge clk);
    kexp_done = 1'b0;
    check("short_err", key_err, 1);
    check("short_not_ready", key_ready, 0);
    req0 = 1'b1; rnd0 = 4'd0;
    @(negedge clk);
    req0 = 1'b0;
    check("err_drop_gnt0", gnt0, 0);
    check("err_drop_bad", rk_bad, 0);
    check("err_rk_hold", rk_out, last_rk_m);

    // Fault: a 61st word.
    kf = rand256(); expand(kf);
    load_key(kf);
    wait_start(kf);
    stream(WORDS + 1, 0, 0);
    check("extra_word_err", key_err, 1);
    check("extra_word_not_ready", key_ready, 0);

    // Fault: no done before the timeout.
    kf = rand256(); expand(kf);
    load_key(kf);
    wait_start(kf);
    stream(WORDS, 0, 0);
    cyc = WORDS;
    while (key_err !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_err", key_err, 1);
    check("timeout_not_ready", key_ready, 0);
    check("timeout_cycles", (cyc >= 254) && (cyc <= 258), 1);

    // Reset in the middle of COLLECT abandons the expansion.
    kf = rand256(); expand(kf);
    load_key(kf);
    wait_start(kf);
    stream(20, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    n_st = 0;
    repeat (20) begin
      @(negedge clk);
      if (kexp_start !== 1'b0) n_st++;
    end
    check("midrst_no_restart", n_st, 0);
    check("midrst_still_idle", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
